// File: rtl/sd_phase_seq.sv
// Programmable multi-phase sequencer: a start pulse runs PHASES phases of sampled length, then pulses fin.
// Optional macro SD_PHASE_SEQ_REPEAT_EN adds repeat_en for continuous re-run without a DONE cycle.
module sd_phase_seq #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = $clog2(PHASES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    xs,
  input  logic                    abort,
`ifdef SD_PHASE_SEQ_REPEAT_EN
  input  logic                    repeat_en,
`endif
  input  logic [PHASES*CNT_W-1:0] len,
  output logic                    busy,
  output logic [PHASES-1:0]       phase,
  output logic [IDX_W-1:0]        phase_idx,
  output logic                    fin,
  output logic                    err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(PHASES - 1);

  state_t                         r_state, w_state_nx;
  logic [PHASES-1:0][CNT_W-1:0]   r_len, w_len_nx, w_len_in;
  logic [IDX_W-1:0]               r_idx, w_idx_nx, w_idx_inc;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nx;
  logic                           r_err;
  logic                           w_run, w_rep, w_fin;

  assign w_len_in  = len;
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_run     = (r_state == S_RUN);

`ifdef SD_PHASE_SEQ_REPEAT_EN
  assign w_rep = repeat_en;
`else
  assign w_rep = 1'b0;
`endif

  // A zero length is clamped to one cycle, so the counter seed is len-1 floored at 0.
  function automatic logic [CNT_W-1:0] seed_cnt(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - CNT_W'(1);
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_len_nx   = r_len;
    w_fin      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_fin = (r_state == S_DONE);
        if (xs && !abort) begin
          w_state_nx = S_RUN;
          w_len_nx   = w_len_in;
          w_idx_nx   = '0;
          w_cnt_nx   = seed_cnt(w_len_in[0]);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else if (r_idx != LAST) begin
          w_idx_nx = w_idx_inc;
          w_cnt_nx = seed_cnt(r_len[w_idx_inc]);
        end else if (w_rep) begin
          // Repeat: fin marks the last phase cycle and lengths are re-sampled live.
          w_fin    = 1'b1;
          w_len_nx = w_len_in;
          w_idx_nx = '0;
          w_cnt_nx = seed_cnt(w_len_in[0]);
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_len   <= w_len_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_run && xs;
    end
  end

  for (genvar g = 0; g < PHASES; g++) begin : g_phase
    assign phase[g] = w_run && (r_idx == IDX_W'(g));
  end

  assign busy      = w_run;
  assign phase_idx = w_run ? r_idx : '0;
  assign fin       = w_fin;
  assign err       = r_err;

endmodule

// File: tb/tb_sd_phase_seq.sv
// Directed bench for sd_phase_seq (PHASES=4, CNT_W=8); expected values are hand-derived per cycle.
module tb_sd_phase_seq;
  logic        clk = 1'b0;
  logic        reset, xs, abort;
  logic [31:0] len;
  logic        busy, fin, err;
  logic [3:0]  phase;
  logic [1:0]  phase_idx;
`ifdef SD_PHASE_SEQ_REPEAT_EN
  logic        repeat_en;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sd_phase_seq #(.PHASES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .xs(xs), .abort(abort),
`ifdef SD_PHASE_SEQ_REPEAT_EN
    .repeat_en(repeat_en),
`endif
    .len(len), .busy(busy), .phase(phase), .phase_idx(phase_idx), .fin(fin), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b, input logic [3:0] ph,
                         input logic [1:0] ix, input logic f, input logic e);
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".phase"}, 32'(phase),     32'(ph));
    chk({tag, ".idx"},   32'(phase_idx), 32'(ix));
    chk({tag, ".fin"},   32'(fin),       32'(f));
    chk({tag, ".err"},   32'(err),       32'(e));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] phA [10] = '{1, 1, 2, 2, 2, 4, 8, 8, 8, 8};
    logic [1:0] ixA [10] = '{0, 0, 1, 1, 1, 2, 3, 3, 3, 3};
    logic [3:0] phC [5]  = '{1, 1, 2, 4, 8};
    logic [1:0] ixC [5]  = '{0, 0, 1, 2, 3};
    logic       erC [5]  = '{0, 1, 1, 1, 1};

    reset = 1'b0; xs = 1'b0; abort = 1'b0; len = '0;
`ifdef SD_PHASE_SEQ_REPEAT_EN
    repeat_en = 1'b0;
`endif
    #2;
    chk_out("rst", 0, 4'h0, 0, 0, 0);
    tick; tick;
    reset = 1'b1;
    tick;
    chk_out("idle", 0, 4'h0, 0, 0, 0);

    // A: lengths {4,1,3,2}; len changed mid-run must not matter
    len = 32'h04010302; xs = 1'b1;
    tick;
    xs = 1'b0; len = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk_out($sformatf("A%0d", i), 1, phA[i], ixA[i], 0, 0);
      tick;
    end
    chk_out("A.done", 0, 4'h0, 0, 1, 0);
    tick;
    chk_out("A.idle", 0, 4'h0, 0, 0, 0);

    // B: all-zero lengths clamp to one cycle each; then abort beats xs in DONE
    len = 32'h0; xs = 1'b1;
    tick;
    xs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("B%0d", i), 1, 4'(1 << i), 2'(i), 0, 0);
      tick;
    end
    chk_out("B.done", 0, 4'h0, 0, 1, 0);
    xs = 1'b1; abort = 1'b1;
    tick;
    xs = 1'b0; abort = 1'b0;
    chk_out("B.abortwin", 0, 4'h0, 0, 0, 0);
    tick;
    chk_out("B.stayidle", 0, 4'h0, 0, 0, 0);

    // C: xs held high -> err from 2nd RUN cycle, back-to-back restart after DONE
    len = 32'h01010102; xs = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("C%0d", i), 1, phC[i], ixC[i], 0, erC[i]);
      tick;
    end
    chk_out("C.done", 0, 4'h0, 0, 1, 1);
    tick;
    chk_out("C.b2b", 1, 4'h1, 0, 0, 0);
    xs = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_out("C.abort", 0, 4'h0, 0, 0, 0);

    // D: abort during phase 1 -> idle next edge, no fin afterwards
    len = 32'h01010302; xs = 1'b1;
    tick;
    xs = 1'b0;
    chk_out("D0", 1, 4'h1, 0, 0, 0);
    tick;
    chk_out("D1", 1, 4'h1, 0, 0, 0);
    tick;
    chk_out("D2", 1, 4'h2, 1, 0, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk_out("D.abort", 0, 4'h0, 0, 0, 0);
    tick;
    chk_out("D.nofin0", 0, 4'h0, 0, 0, 0);
    tick;
    chk_out("D.nofin1", 0, 4'h0, 0, 0, 0);

    // E: xs and abort together in IDLE -> no start
    xs = 1'b1; abort = 1'b1;
    tick;
    xs = 1'b0; abort = 1'b0;
    chk_out("E0", 0, 4'h0, 0, 0, 0);
    tick;
    chk_out("E1", 0, 4'h0, 0, 0, 0);

    // F: async reset in phase 2, then clean restart
    len = 32'h04010302; xs = 1'b1;
    tick;
    xs = 1'b0;
    repeat (5) tick;
    chk_out("F.ph2", 1, 4'h4, 2, 0, 0);
    #3 reset = 1'b0;
    #1;
    chk_out("F.async", 0, 4'h0, 0, 0, 0);
    tick;
    reset = 1'b1;
    chk_out("F.held", 0, 4'h0, 0, 0, 0);
    tick;
    chk_out("F.rel", 0, 4'h0, 0, 0, 0);
    xs = 1'b1;
    tick;
    xs = 1'b0;
    chk_out("F0", 1, 4'h1, 0, 0, 0);
    tick;
    chk_out("F1", 1, 4'h1, 0, 0, 0);
    tick;
    chk_out("F2", 1, 4'h2, 1, 0, 0);
    repeat (8) tick;
    chk_out("F.done", 0, 4'h0, 0, 1, 0);
    tick;

`ifdef SD_PHASE_SEQ_REPEAT_EN
    // R: repeat mode cycles phases continuously with fin in each last-phase cycle
    repeat_en = 1'b1; len = 32'h01010101; xs = 1'b1;
    tick;
    xs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("R%0d", i), 1, 4'(1 << (i % 4)), 2'(i % 4), (i % 4) == 3, 0);
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0; repeat_en = 1'b0;
    chk_out("R.abort", 0, 4'h0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
